// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: Avalon-MM slave that sequences an external accumulator.
// A START write clears the accumulator, streams LEN samples into it over a
// valid/ready handshake, waits one cycle for the sum to settle, captures it
// into RESULT and raises the done level for software polling.
//
// Optional build macro ACCUM_SEQ_IRQ_EN adds an irq output gated by a stored
// IRQ_ENABLE bit (CTRL bit2), which then reads back at CTRL.
//
// Sample handshake: a sample moves from the source into the accumulator on
// any clock edge where smp_valid && smp_ready are both high. smp_ready
// depends only on FSM state (and a same-cycle ABORT write), never on
// smp_valid. acc_en mirrors that transfer combinationally so the accumulator
// adds acc_in on the same edge.
module accum_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_valid,
  output logic              smp_ready,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [DATA_W-1:0] acc_in,
  input  logic [ACC_W-1:0]  acc_value,
  output logic              done,
`ifdef ACCUM_SEQ_IRQ_EN
  output logic              irq,
`endif
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LEN    = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] len_run;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] result;
  logic             done_r;
  logic             irq_en;

  logic wr_ctrl;
  logic start_req;
  logic abort_req;
  logic start_go;
  logic status_clr;
  logic busy;
  logic xfer;
  logic settle_exit;
  logic [31:0] rd_mux;
  logic unused_wd;

  // Bus write decode; ABORT takes priority over START in the same write.
  always_comb begin
    wr_ctrl    = avs_write && (avs_address == A_CTRL);
    abort_req  = wr_ctrl && avs_writedata[1];
    start_req  = wr_ctrl && avs_writedata[0] && !avs_writedata[1];
    start_go   = start_req && (state == ST_IDLE);
    status_clr = avs_write && (avs_address == A_STATUS) && avs_writedata[1];
  end

  // Datapath-facing strobes derived from state and the handshake.
  always_comb begin
    busy        = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_SETTLE);
    smp_ready   = (state == ST_RUN) && !abort_req;
    xfer        = smp_ready && smp_valid;
    acc_en      = xfer;
    acc_in      = smp_data;
    acc_clr     = (state == ST_CLEAR);
    settle_exit = (state == ST_SETTLE) && !abort_req;
  end

  // Next-state logic for the run sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_go) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (abort_req)              state_nxt = ST_IDLE;
        else if (len_run == '0)     state_nxt = ST_SETTLE;
        else                        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort_req)                          state_nxt = ST_IDLE;
        else if (xfer && (cnt == CNT_W'(1)))    state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort_req) state_nxt = ST_IDLE;
        else           state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // LEN register: software writes land only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_reg <= '0;
    end else if (avs_write && (avs_address == A_LEN) && !busy) begin
      len_reg <= avs_writedata[CNT_W-1:0];
    end
  end

  // Running length is latched at START so the run is immune to later writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         len_run <= '0;
    else if (start_go) len_run <= len_reg;
  end

  // Remaining-sample counter: loaded in CLEAR, decremented per transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= len_run;
    end else if (xfer) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // RESULT captures the settled accumulator value when SETTLE completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            result <= '0;
    else if (settle_exit) result <= acc_value;
  end

  // done level: set on entry to DONE, cleared by a new START or STATUS write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       done_r <= 1'b0;
    else if (settle_exit)            done_r <= 1'b1;
    else if (start_go || status_clr) done_r <= 1'b0;
  end

`ifdef ACCUM_SEQ_IRQ_EN
  // IRQ_ENABLE is rewritten by every CTRL write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        irq_en <= 1'b0;
    else if (wr_ctrl) irq_en <= avs_writedata[2];
  end

  assign irq = done_r && irq_en;
`else
  assign irq_en = 1'b0;
`endif

  // Read mux; unmapped bits are zero.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_CTRL:   rd_mux[2] = irq_en;
      A_LEN:    rd_mux[CNT_W-1:0] = len_reg;
      A_STATUS: rd_mux[1:0] = {done_r, busy};
      A_RESULT: rd_mux[ACC_W-1:0] = result;
      default:  rd_mux = '0;
    endcase
  end

  // Registered read data, valid the cycle after avs_read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

  assign done      = done_r;
  assign fsm_state = state;
  assign unused_wd = ^avs_writedata;

endmodule
